jtag_scan_sequencer: RTL and testbench

JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

---
 rtl/jtag_scan_pkg.sv | 51 +++++
 rtl/jtag_scan_tckgen.sv | 42 ++++
 rtl/jtag_scan_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_jtag_scan_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_scan_pkg.sv
// rtl/jtag_scan_pkg.sv - op/state encodings and fixed TMS sequences for the JTAG scan sequencer
// JTAG_SCAN_TRST_EN adds the TRST state used by the TAP reset op.
package jtag_scan_pkg;

   typedef enum logic [1:0] {
      OP_IR    = 2'b00,
      OP_DR    = 2'b01,
      OP_RESET = 2'b10,
      OP_IDLE  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_SHIFT = 3'd2,
      ST_POST  = 3'd3,
      ST_RESP  = 3'd4
`ifdef JTAG_SCAN_TRST_EN
      , ST_TRST = 3'd5
`endif
   } state_e;

   // Bit i of each sequence is the TMS value of TCK i, starting from Run-Test/Idle.
   localparam logic [7:0] IR_PRE_TMS = 8'b0000_0011;
   localparam logic [2:0] IR_PRE_LEN = 3'd4;
   localparam logic [7:0] DR_PRE_TMS = 8'b0000_0001;
   localparam logic [2:0] DR_PRE_LEN = 3'd3;
   localparam logic [7:0] RST_TMS    = 8'b0001_1111;
   localparam logic [2:0] RST_LEN    = 3'd6;
   localparam logic [1:0] POST_TMS   = 2'b01;
   localparam logic [2:0] TRST_LEN   = 3'd4;

   function automatic logic [2:0] pre_len(op_e op);
      case (op)
         OP_IR:   return IR_PRE_LEN;
         OP_DR:   return DR_PRE_LEN;
         default: return RST_LEN;
      endcase
   endfunction

   function automatic logic pre_tms(op_e op, logic [2:0] idx);
      logic [7:0] seq;
      case (op)
         OP_IR:   seq = IR_PRE_TMS;
         OP_DR:   seq = DR_PRE_TMS;
         default: seq = RST_TMS;
      endcase
      return seq[idx];
   endfunction

endpackage

// File: rtl/jtag_scan_tckgen.sv
// rtl/jtag_scan_tckgen.sv - TCK divider producing alternating fall/rise strobes
// The first strobe after enable is always a fall; tck is low while disabled.
module jtag_scan_tckgen #(
   parameter int CLK_DIV = 4
) (
   input  logic ref_clk,
   input  logic rst_a,
   input  logic enable,
   output logic tck,
   output logic rise,
   output logic fall
);

   logic [7:0] cnt_q;
   logic       phase_q;
   logic       tck_q;
   logic       at_end;

   assign at_end = enable && (cnt_q == 8'(CLK_DIV - 1));
   assign rise   = at_end && phase_q;
   assign fall   = at_end && !phase_q;
   assign tck    = tck_q;

   always_ff @(posedge ref_clk or posedge rst_a) begin
      if (rst_a) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         tck_q   <= 1'b0;
      end else if (!enable) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         tck_q   <= 1'b0;
      end else if (at_end) begin
         cnt_q   <= '0;
         phase_q <= !phase_q;
         tck_q   <= phase_q;
      end else begin
         cnt_q   <= cnt_q + 8'd1;
      end
   end

endmodule

// File: rtl/jtag_scan_sequencer.sv
// rtl/jtag_scan_sequencer.sv - command-driven JTAG IR/DR scan, TAP reset and idle sequencer
// JTAG_SCAN_TRST_EN adds a 4-TCK jtag_trstn pulse ahead of the TAP reset op.
module jtag_scan_sequencer
   import jtag_scan_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = 64
) (
   input  logic               ref_clk,
   input  logic               rst_a,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [6:0]         cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               jtag_tck,
   output logic               jtag_tms,
   output logic               jtag_tdi,
   output logic               jtag_trstn,
   input  logic               jtag_tdo,
   output logic               busy
);

   localparam int IW = 8;
   localparam logic [IW-1:0] MAX_LEN_W = IW'(MAX_LEN);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [IW-1:0]      len_q, len_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [MAX_LEN-1:0] cap_mask_q, cap_mask_d;
   logic [MAX_LEN-1:0] rsp_q, rsp_d;
   logic               done_q, done_d;
   logic               shift_bit_q, shift_bit_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic               run, rise, fall, is_scan, last_bit;

   assign run      = (state_q != ST_IDLE) && (state_q != ST_RESP);
   assign is_scan  = (op_q == OP_IR) || (op_q == OP_DR);
   assign last_bit = (idx_q == len_q - IW'(1));

   jtag_scan_tckgen #(.CLK_DIV(CLK_DIV)) u_tckgen (
      .ref_clk (ref_clk),
      .rst_a   (rst_a),
      .enable  (run),
      .tck     (jtag_tck),
      .rise    (rise),
      .fall    (fall)
   );

`ifdef JTAG_SCAN_TRST_EN
   logic trstn_q, trstn_d;
   assign jtag_trstn = trstn_q;
`else
   assign jtag_trstn = 1'b1;
`endif

   assign cmd_ready = (state_q == ST_IDLE) && !rst_a;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = rsp_q;
   assign busy      = (state_q != ST_IDLE);
   assign jtag_tms  = tms_q;
   assign jtag_tdi  = tdi_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      len_d       = len_q;
      idx_d       = idx_q;
      data_d      = data_q;
      cap_mask_d  = cap_mask_q;
      rsp_d       = rsp_q;
      done_d      = done_q;
      shift_bit_d = shift_bit_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
`ifdef JTAG_SCAN_TRST_EN
      trstn_d     = trstn_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d        = op_e'(cmd_op);
               len_d       = (cmd_len == 7'd0 || IW'(cmd_len) > MAX_LEN_W) ? MAX_LEN_W : IW'(cmd_len);
               data_d      = cmd_data;
               idx_d       = '0;
               done_d      = 1'b0;
               shift_bit_d = 1'b0;
               cap_mask_d  = {{(MAX_LEN-1){1'b0}}, 1'b1};
               rsp_d       = '0;
               case (op_e'(cmd_op))
                  OP_IDLE:  state_d = ST_SHIFT;
`ifdef JTAG_SCAN_TRST_EN
                  OP_RESET: state_d = ST_TRST;
`endif
                  default:  state_d = ST_PRE;
               endcase
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: begin
            // TDO is captured on the rise that follows a fall which drove a shift bit.
            if (rise && shift_bit_q) begin
               rsp_d      = rsp_q | (jtag_tdo ? cap_mask_q : '0);
               cap_mask_d = cap_mask_q << 1;
            end
            if (fall) begin
               shift_bit_d = 1'b0;
               idx_d       = idx_q + IW'(1);
               if (done_q) begin
                  state_d = ST_RESP;
               end else begin
                  case (state_q)
`ifdef JTAG_SCAN_TRST_EN
                     ST_TRST: begin
                        tms_d   = 1'b1;
                        trstn_d = 1'b0;
                        if (idx_q == IW'(TRST_LEN) - IW'(1)) begin
                           idx_d   = '0;
                           state_d = ST_PRE;
                        end
                     end
`endif
                     ST_PRE: begin
                        tms_d = pre_tms(op_q, idx_q[2:0]);
`ifdef JTAG_SCAN_TRST_EN
                        trstn_d = 1'b1;
`endif
                        if (idx_q[2:0] == pre_len(op_q) - 3'd1) begin
                           idx_d = '0;
                           if (op_q == OP_RESET) done_d  = 1'b1;
                           else                  state_d = ST_SHIFT;
                        end
                     end
                     ST_SHIFT: begin
                        tms_d       = is_scan && last_bit;
                        tdi_d       = is_scan && data_q[0];
                        data_d      = data_q >> 1;
                        shift_bit_d = is_scan;
                        if (last_bit) begin
                           idx_d = '0;
                           if (is_scan) state_d = ST_POST;
                           else         done_d  = 1'b1;
                        end
                     end
                     ST_POST: begin
                        tms_d = POST_TMS[idx_q[0]];
                        if (idx_q[0]) done_d = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase
   end

   always_ff @(posedge ref_clk or posedge rst_a) begin
      if (rst_a) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_IR;
         len_q       <= '0;
         idx_q       <= '0;
         data_q      <= '0;
         cap_mask_q  <= '0;
         rsp_q       <= '0;
         done_q      <= 1'b0;
         shift_bit_q <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
`ifdef JTAG_SCAN_TRST_EN
         trstn_q     <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         cap_mask_q  <= cap_mask_d;
         rsp_q       <= rsp_d;
         done_q      <= done_d;
         shift_bit_q <= shift_bit_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
`ifdef JTAG_SCAN_TRST_EN
         trstn_q     <= trstn_d;
`endif
      end
   end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb/tb_jtag_scan_sequencer.sv - scoreboard bench for jtag_scan_sequencer (CLK_DIV=2)
// Expected responses are queued at issue; a negedge monitor pops and compares on handshake.
module tb_jtag_scan_sequencer;

   localparam int CLK_DIV = 2;
   localparam int MAX_LEN = 64;

   logic               ref_clk = 1'b0;
   logic               rst_a = 1'b1;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [1:0]         cmd_op = 2'b00;
   logic [6:0]         cmd_len = 7'd0;
   logic [MAX_LEN-1:0] cmd_data = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b1;
   logic [MAX_LEN-1:0] rsp_data;
   logic               jtag_tck, jtag_tms, jtag_tdi, jtag_trstn, jtag_tdo;
   logic               busy;
   int                 tdo_mode = 0;

   assign jtag_tdo = (tdo_mode == 0) ? jtag_tdi : (tdo_mode == 1) ? 1'b1 : ~jtag_tdi;

   jtag_scan_sequencer #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
      .ref_clk    (ref_clk),
      .rst_a      (rst_a),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_len    (cmd_len),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .jtag_tck   (jtag_tck),
      .jtag_tms   (jtag_tms),
      .jtag_tdi   (jtag_tdi),
      .jtag_trstn (jtag_trstn),
      .jtag_tdo   (jtag_tdo),
      .busy       (busy)
   );

   always #5 ref_clk = ~ref_clk;

   typedef struct {
      logic [63:0]  data;
      int           ntck;
      logic [127:0] tms;
      int           trst_low;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0;
   int           n_pass = 0;
   int           tck_cnt = 0;
   int           trst_low = 0;
   int           since_rise = 0;
   int           per_min = 1000;
   int           per_max = 0;
   logic         have_rise = 1'b0;
   logic         tck_prev = 1'b0;
   logic [127:0] tms_rec = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [63:0] d, input int n, input logic [127:0] t, input int tl);
      exp_t e;
      e.data = d; e.ntck = n; e.tms = t; e.trst_low = tl;
      sb.push_back(e);
   endtask

   // Monitor: response compare on handshake, TCK/TMS recording between accepts.
   always @(negedge ref_clk) begin
      exp_t e;
      if (rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: got rsp_data %0h with no expected entry", rsp_data);
         end else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("tck_count", tck_cnt, e.ntck);
            chk("tms_seq", tms_rec, e.tms);
            chk("trstn_low_tcks", trst_low, e.trst_low);
            if (e.ntck > 1) begin
               chk("tck_period_min", per_min, 2 * CLK_DIV);
               chk("tck_period_max", per_max, 2 * CLK_DIV);
            end
         end
      end
      if (cmd_valid && cmd_ready) begin
         tck_cnt = 0; trst_low = 0; tms_rec = '0;
         per_min = 1000; per_max = 0; since_rise = 0; have_rise = 1'b0;
      end else begin
         since_rise++;
         if (jtag_tck && !tck_prev) begin
            if (have_rise) begin
               if (since_rise < per_min) per_min = since_rise;
               if (since_rise > per_max) per_max = since_rise;
            end
            have_rise = 1'b1;
            since_rise = 0;
            if (tck_cnt < 128) tms_rec[tck_cnt] = jtag_tms;
            if (!jtag_trstn) trst_low++;
            tck_cnt++;
         end
      end
      tck_prev = jtag_tck;
   end

   task automatic wait_accept();
      int n;
      n = 0;
      @(negedge ref_clk);
      while (!cmd_ready && n < 3000) begin
         @(negedge ref_clk);
         n++;
      end
      chk("cmd_accept", cmd_ready, 1'b1);
      @(posedge ref_clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic send(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
      @(posedge ref_clk);
      #1;
      cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
      wait_accept();
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge ref_clk);
         n++;
      end
      chk("sb_drained", sb.size(), 0);
      repeat (2) @(negedge ref_clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tck"}, jtag_tck, 1'b0);
      chk({tag, "_tms"}, jtag_tms, 1'b1);
      chk({tag, "_tdi"}, jtag_tdi, 1'b0);
      chk({tag, "_trstn"}, jtag_trstn, 1'b1);
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_rsp_data"}, rsp_data, '0);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic push_tap_reset();
`ifdef JTAG_SCAN_TRST_EN
      push(64'h0, 10, 128'h1FF, 4);
`else
      push(64'h0, 6, 128'h1F, 0);
`endif
   endtask

   initial begin
      logic [127:0] v;
      logic         seen;
      int           n;

      repeat (3) @(negedge ref_clk);
      chk_reset_outputs("reset");
      @(posedge ref_clk);
      #1 rst_a = 1'b0;
      repeat (2) @(negedge ref_clk);
      chk("idle_cmd_ready", cmd_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_tck", jtag_tck, 1'b0);

      push_tap_reset();
      send(2'b10, 7'd0, 64'h0);
      wait_drain();

      tdo_mode = 0;
      push(64'h15, 11, 128'h303, 0);
      send(2'b00, 7'd5, 64'h15);
      wait_drain();

      tdo_mode = 1;
      push(64'h1F, 11, 128'h303, 0);
      send(2'b00, 7'd5, 64'h15);
      wait_drain();

      tdo_mode = 2;
      push(64'h2A, 12, 128'h601, 0);
      send(2'b01, 7'd7, 64'h55);
      wait_drain();

      tdo_mode = 0;
      v = '0; v[0] = 1'b1; v[66] = 1'b1; v[67] = 1'b1;
      push(64'hDEADBEEF_01234567, 69, v, 0);
      send(2'b01, 7'd0, 64'hDEADBEEF_01234567);
      wait_drain();

      push(64'h0, 3, 128'h0, 0);
      send(2'b11, 7'd3, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_drain();

      // Response backpressure with a second command waiting.
      @(posedge ref_clk);
      #1 rsp_ready = 1'b0;
      push(64'hA, 9, 128'hC1, 0);
      send(2'b01, 7'd4, 64'hA);
      n = 0;
      while (!rsp_valid && n < 500) begin
         @(negedge ref_clk);
         n++;
      end
      chk("bp_rsp_valid_seen", rsp_valid, 1'b1);
      @(posedge ref_clk);
      #1;
      cmd_op = 2'b11; cmd_len = 7'd2; cmd_data = 64'h0; cmd_valid = 1'b1;
      push(64'h0, 2, 128'h0, 0);
      repeat (20) begin
         @(negedge ref_clk);
         chk("bp_rsp_valid", rsp_valid, 1'b1);
         chk("bp_rsp_data", rsp_data, 64'hA);
         chk("bp_cmd_ready", cmd_ready, 1'b0);
         chk("bp_busy", busy, 1'b1);
      end
      @(posedge ref_clk);
      #1 rsp_ready = 1'b1;
      wait_accept();
      wait_drain();

      // Reset during shift bit 3 of a DR scan (PRE takes TCKs 1..3).
      send(2'b01, 7'd8, 64'h5A);
      n = 0;
      while (tck_cnt < 7 && n < 500) begin
         @(negedge ref_clk);
         n++;
      end
      chk("mid_scan_tck_reached", tck_cnt, 7);
      @(posedge ref_clk);
      #1 rst_a = 1'b1;
      #1 chk_reset_outputs("midrst");
      repeat (3) @(posedge ref_clk);
      #1 rst_a = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge ref_clk);
         seen = seen | rsp_valid;
      end
      chk("no_rsp_after_rst", seen, 1'b0);

      push_tap_reset();
      send(2'b10, 7'd0, 64'h0);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
